// File: rtl/arithmetic_ip.sv
// Purpose : registered 2-bit arithmetic unit (add / subtract / multiply / divide) selected by M.
// Latency : one cycle from an in_valid edge to the out_valid cycle carrying its result.
// Backpres: none; a new operand set can be accepted every cycle, and outputs hold while in_valid is low.
module arithmetic_ip (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic [1:0] M,
   output logic [2:0] S,
   output logic       Cout,
   output logic [2:0] Sr,
   output logic       out_valid
);

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_MUL = 2'b10;
   localparam logic [1:0] MODE_DIV = 2'b11;

   // Raw results of every operation, computed in parallel and muxed by mode.
   logic [2:0] sum;
   logic [2:0] diff;
   logic [3:0] prod;
   logic [1:0] divisor;
   logic [1:0] quo;
   logic [1:0] rem;
   logic       div_zero;

   logic [2:0] s_nxt;
   logic       cout_nxt;
   logic [2:0] sr_nxt;

   assign sum      = {1'b0, A} + {1'b0, B};
   assign diff     = {1'b0, A} - {1'b0, B};
   assign prod     = {2'b00, A} * {2'b00, B};
   assign div_zero = (B == 2'b00);

   // The divider never sees a zero divisor; the B=0 case is overridden below,
   // so the substituted divisor only keeps the arithmetic free of X.
   assign divisor  = div_zero ? 2'b01 : B;
   assign quo      = A / divisor;
   assign rem      = A % divisor;

   // Select the result for the current mode; every encoding is defined.
   always_comb begin
      s_nxt    = 3'b000;
      cout_nxt = 1'b0;
      sr_nxt   = 3'b000;
      case (M)
         MODE_ADD: begin
            s_nxt    = sum;
            cout_nxt = sum[2];
         end
         MODE_SUB: begin
            s_nxt    = diff;
            cout_nxt = (A < B);
         end
         MODE_MUL: begin
            s_nxt    = prod[2:0];
            cout_nxt = prod[3];
         end
         MODE_DIV: begin
            if (div_zero) begin
               s_nxt    = 3'b111;
               cout_nxt = 1'b1;
               sr_nxt   = {1'b0, A};
            end else begin
               s_nxt    = {1'b0, quo};
               cout_nxt = 1'b0;
               sr_nxt   = {1'b0, rem};
            end
         end
         default: begin
            s_nxt    = 3'b000;
            cout_nxt = 1'b0;
            sr_nxt   = 3'b000;
         end
      endcase
   end

   // Result registers: load on in_valid, otherwise hold the last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= 3'b000;
         Cout <= 1'b0;
         Sr   <= 3'b000;
      end else if (in_valid) begin
         S    <= s_nxt;
         Cout <= cout_nxt;
         Sr   <= sr_nxt;
      end
   end

   // Output strobe: one cycle per accepted operand set; reset drops any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_arithmetic_ip.sv
// Purpose : self-checking bench for arithmetic_ip using an expected-result queue.
// Latency : results are compared one cycle after the operands are driven.
// Backpres: not applicable; in_valid is driven freely by the bench.
module tb_arithmetic_ip;

   typedef struct packed {
      logic [2:0] s;
      logic       c;
      logic [2:0] r;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] A;
   logic [1:0] B;
   logic [1:0] M;
   logic [2:0] S;
   logic       Cout;
   logic [2:0] Sr;
   logic       out_valid;

   int   checks;
   int   errors;
   res_t sb[$];

   arithmetic_ip dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .M         (M),
      .S         (S),
      .Cout      (Cout),
      .Sr        (Sr),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model written directly from the arithmetic definitions.
   function automatic res_t model(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
      res_t r;
      int   x;
      r = '0;
      case (m)
         2'b00: begin
            x   = int'(a) + int'(b);
            r.s = x[2:0];
            r.c = (x > 3);
         end
         2'b01: begin
            x   = int'(a) - int'(b);
            r.s = x[2:0];
            r.c = (int'(a) < int'(b));
         end
         2'b10: begin
            x   = int'(a) * int'(b);
            r.s = x[2:0];
            r.c = (x >= 8);
         end
         default: begin
            if (b == 2'b00) begin
               r.s = 3'b111;
               r.c = 1'b1;
               r.r = {1'b0, a};
            end else begin
               x   = int'(a) / int'(b);
               r.s = x[2:0];
               x   = int'(a) % int'(b);
               r.r = x[2:0];
               r.c = 1'b0;
            end
         end
      endcase
      return r;
   endfunction

   // Drive one operand set with in_valid high, queue its expected result,
   // and return #1 after the capturing edge.
   task automatic drive_op(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b, input res_t exp);
      @(negedge clk);
      in_valid = 1'b1;
      M        = m;
      A        = a;
      B        = b;
      sb.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      res_t got;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A = 2'b00; B = 2'b00; M = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      got = {S, Cout, Sr};
      checks++;
      if (got !== 7'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: got S=%b Cout=%b Sr=%b vld=%b, want all zero", S, Cout, Sr, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Load a nonzero result so the asynchronous clear is observable.
      @(negedge clk);
      in_valid = 1'b1; M = 2'b00; A = 2'b11; B = 2'b11;
      @(posedge clk);
      #1;
      checks++;
      if (S !== 3'b110 || Cout !== 1'b1 || Sr !== 3'b000 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_preload: got S=%b Cout=%b Sr=%b vld=%b, want S=110 Cout=1 Sr=000 vld=1", S, Cout, Sr, out_valid);
      end
      // Mid-cycle assertion with in_valid still high: outputs clear without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (S !== 3'b000 || Cout !== 1'b0 || Sr !== 3'b000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got S=%b Cout=%b Sr=%b vld=%b, want all zero", S, Cout, Sr, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (S !== 3'b000 || Cout !== 1'b0 || Sr !== 3'b000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got S=%b Cout=%b Sr=%b vld=%b, want all zero", S, Cout, Sr, out_valid);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (S !== 3'b000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got S=%b vld=%b, want S=000 vld=0", S, out_valid);
      end
      sb.delete();
   endtask

   task automatic test_add();
      res_t got, exp;
      drive_op(2'b00, 2'b11, 2'b11, res_t'({3'b110, 1'b1, 3'b000}));
      for (int i = 0; i < 2; i++) begin
         if (i == 1) drive_op(2'b00, 2'b01, 2'b10, res_t'({3'b011, 1'b0, 3'b000}));
         got = {S, Cout, Sr};
         exp = (sb.size() != 0) ? sb.pop_front() : 'x;
         checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL add[%0d]: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=1",
                     i, S, Cout, Sr, out_valid, exp.s, exp.c, exp.r);
         end
      end
   endtask

   task automatic test_sub();
      res_t got, exp;
      res_t tbl [3];
      logic [1:0] ta [3];
      logic [1:0] tb [3];
      ta[0] = 2'b01; tb[0] = 2'b10; tbl[0] = {3'b111, 1'b1, 3'b000};
      ta[1] = 2'b11; tb[1] = 2'b01; tbl[1] = {3'b010, 1'b0, 3'b000};
      ta[2] = 2'b10; tb[2] = 2'b10; tbl[2] = {3'b000, 1'b0, 3'b000};
      for (int i = 0; i < 3; i++) begin
         drive_op(2'b01, ta[i], tb[i], tbl[i]);
         got = {S, Cout, Sr};
         exp = (sb.size() != 0) ? sb.pop_front() : 'x;
         checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL sub[%0d]: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=1",
                     i, S, Cout, Sr, out_valid, exp.s, exp.c, exp.r);
         end
      end
   endtask

   task automatic test_mul();
      res_t got, exp;
      res_t tbl [3];
      logic [1:0] ta [3];
      logic [1:0] tb [3];
      ta[0] = 2'b11; tb[0] = 2'b11; tbl[0] = {3'b001, 1'b1, 3'b000};
      ta[1] = 2'b10; tb[1] = 2'b11; tbl[1] = {3'b110, 1'b0, 3'b000};
      ta[2] = 2'b00; tb[2] = 2'b11; tbl[2] = {3'b000, 1'b0, 3'b000};
      for (int i = 0; i < 3; i++) begin
         drive_op(2'b10, ta[i], tb[i], tbl[i]);
         got = {S, Cout, Sr};
         exp = (sb.size() != 0) ? sb.pop_front() : 'x;
         checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL mul[%0d]: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=1",
                     i, S, Cout, Sr, out_valid, exp.s, exp.c, exp.r);
         end
      end
   endtask

   task automatic test_div();
      res_t got, exp;
      res_t tbl [3];
      logic [1:0] ta [3];
      logic [1:0] tb [3];
      ta[0] = 2'b11; tb[0] = 2'b10; tbl[0] = {3'b001, 1'b0, 3'b001};
      ta[1] = 2'b10; tb[1] = 2'b11; tbl[1] = {3'b000, 1'b0, 3'b010};
      ta[2] = 2'b10; tb[2] = 2'b00; tbl[2] = {3'b111, 1'b1, 3'b010};
      for (int i = 0; i < 3; i++) begin
         drive_op(2'b11, ta[i], tb[i], tbl[i]);
         got = {S, Cout, Sr};
         exp = (sb.size() != 0) ? sb.pop_front() : 'x;
         checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL div[%0d]: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=1",
                     i, S, Cout, Sr, out_valid, exp.s, exp.c, exp.r);
         end
      end
   endtask

   // All 64 {M,A,B} combinations with in_valid held high, then a 3-cycle idle gap.
   task automatic test_back_to_back();
      res_t       got, exp, last;
      logic [5:0] v;
      last = '0;
      for (int i = 0; i < 64; i++) begin
         v = i[5:0];
         drive_op(v[5:4], v[3:2], v[1:0], model(v[5:4], v[3:2], v[1:0]));
         got = {S, Cout, Sr};
         exp = (sb.size() != 0) ? sb.pop_front() : 'x;
         last = exp;
         checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL sweep M=%b A=%b B=%b: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=1",
                     v[5:4], v[3:2], v[1:0], S, Cout, Sr, out_valid, exp.s, exp.c, exp.r);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      M = 2'b11; A = 2'b10; B = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         got = {S, Cout, Sr};
         checks++;
         if (out_valid !== 1'b0 || got !== last) begin
            errors++;
            $display("FAIL idle_hold[%0d]: got S=%b Cout=%b Sr=%b vld=%b, want S=%b Cout=%b Sr=%b vld=0",
                     k, S, Cout, Sr, out_valid, last.s, last.c, last.r);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
